rxtx_link_ctrl: RTL and testbench
=================================

// Module: rxtx_link_ctrl
// PURPOSE
// Link bring-up and frame scheduler on the core side of the LVDS rx/tx bridge, clocked by the bridge core clock.
// Drives the sync-pattern request until the local receiver locks, then holds it so the remote side can lock.
// Once the link is up, issues transmit-start pulses back-to-back and gates valid/credit/pull traffic between the NoC router boundary and the bridge.
// Detects loss of lock and re-trains.
// PARAMETERS
// GATE_WIDTH    4      number of flit lanes per gate (width of valid/credit vectors)
// HOLD_CYCLES   256    cycles sync keeps being generated after local lock (>=1)
// LOCK_TIMEOUT  65535  cycles in SYNC without lock before o_link_err pulses (>=2)
// PORTS
// i_clk            in   1           bridge core clock
// i_rst_n          in   1           asynchronous reset, active-low
// i_enable         in   1           link enable; low forces IDLE
// o_sync_generate  out  1           request sync pattern on the LVDS lanes
// i_sync_complete  in   1           local receiver word-aligned (from auto bitslip)
// o_tx_start       out  1           one-cycle pulse: transmitter captures a gate and starts a frame
// i_tx_done        in   1           transmitter finished current frame
// o_src_accept     out  1           one-cycle pulse to router side: current i_vl/i_cr gate consumed
// i_vl             in   GATE_WIDTH  valid per lane from router side
// i_cr             in   GATE_WIDTH  credit return per lane from router side
// o_vl             out  GATE_WIDTH  valid to transmitter
// o_cr             out  GATE_WIDTH  credit to transmitter
// i_rx_available   in   1           receiver FIFO holds a gate
// i_sink_ready     in   1           router side can accept a received gate
// o_rx_pull        out  1           pop one gate from receiver
// o_link_up        out  1           state == RUN
// o_link_err       out  1           one-cycle pulse on lock timeout
// o_relock_cnt     out  8           count of RUN->SYNC lock losses, saturating
// BEHAVIOUR
// - Reset (i_rst_n=0, async): state=IDLE; all counters 0; busy=0; every output 0.
// - State register, encoding IDLE/SYNC/HOLD/RUN; all transitions on rising i_clk.
// - i_enable=0 in any state -> IDLE next cycle; busy still clears on i_tx_done.
// - IDLE: o_sync_generate=0. i_enable=1 -> SYNC; timeout counter cleared.
// - SYNC: o_sync_generate=1; timeout counter increments each cycle.
//   i_sync_complete=1 -> HOLD, hold counter cleared.
//   Counter reaching LOCK_TIMEOUT-1 without lock: o_link_err=1 for one cycle, counter -> 0, stay in SYNC.
//   If lock and timeout occur in the same cycle, lock wins and no error pulse is issued.
// - HOLD: o_sync_generate=1; hold counter increments.
//   i_sync_complete=0 -> SYNC (no relock count).
//   Counter == HOLD_CYCLES-1 with lock still held -> RUN.
// - RUN: o_sync_generate=0; o_link_up=1.
//   i_sync_complete=0 -> SYNC; o_relock_cnt+1, saturating at 255.
// - o_sync_generate, o_link_up, o_tx_start, o_src_accept, o_link_err are registered outputs.
// - TX scheduling (registered):
//   In RUN with busy=0 and o_tx_start=0: o_tx_start=1 and o_src_accept=1 for exactly one cycle; busy is set at the same edge.
//   busy clears on the cycle i_tx_done=1 is sampled. The next start is issued the following cycle at the earliest, so starts are never closer than 2 cycles apart.
//   No start is issued outside RUN. A frame in flight when lock is lost completes normally (busy clears on done).
// - Gating (combinational):
//   o_vl = i_vl & {GATE_WIDTH{link_up}}; o_cr = i_cr & {GATE_WIDTH{link_up}}.
//   o_rx_pull = link_up & i_rx_available & i_sink_ready. Never asserted outside RUN.
// - Widths: counters are $clog2(max(HOLD_CYCLES,LOCK_TIMEOUT)+1) bits; no wrap except the timeout reload.
// TESTING
// - Reset mid-RUN while busy=1 -> all outputs 0 asynchronously; after release with i_enable=1: IDLE->SYNC, o_sync_generate=1 one cycle later.
// - HOLD_CYCLES=4: i_sync_complete rises in SYNC -> o_sync_generate stays 1 for exactly 4 HOLD cycles, then o_link_up=1.
// - LOCK_TIMEOUT=10, lock never asserted -> o_link_err pulses every 10 cycles; o_link_up stays 0.
// - RUN, i_tx_done returned 3 cycles after each start -> o_tx_start period is 4 cycles; o_src_accept matches o_tx_start pulse for pulse.
// - In RUN drop i_sync_complete 300 times -> o_relock_cnt=255 (saturated); o_vl=0, o_cr=0 and o_rx_pull=0 while not in RUN.
// - RUN, i_rx_available=1, i_sink_ready toggling -> o_rx_pull follows i_sink_ready; i_enable=0 -> o_rx_pull=0 the next cycle.

Source files
------------

// File: rtl/rxtx_link_ctrl.sv
// Link bring-up FSM and frame scheduler for the LVDS rx/tx bridge core side.
// Trains the link with sync, holds sync after local lock, then paces transmit frames and gates router traffic.
module rxtx_link_ctrl #(
    parameter int GATE_WIDTH   = 4,
    parameter int HOLD_CYCLES  = 256,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_enable,
    output logic                  o_sync_generate,
    input  logic                  i_sync_complete,
    output logic                  o_tx_start,
    input  logic                  i_tx_done,
    output logic                  o_src_accept,
    input  logic [GATE_WIDTH-1:0] i_vl,
    input  logic [GATE_WIDTH-1:0] i_cr,
    output logic [GATE_WIDTH-1:0] o_vl,
    output logic [GATE_WIDTH-1:0] o_cr,
    input  logic                  i_rx_available,
    input  logic                  i_sink_ready,
    output logic                  o_rx_pull,
    output logic                  o_link_up,
    output logic                  o_link_err,
    output logic [7:0]            o_relock_cnt
);
    localparam int MAX_CNT = (HOLD_CYCLES > LOCK_TIMEOUT) ? HOLD_CYCLES : LOCK_TIMEOUT;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SYNC, HOLD, RUN} state_t;

    state_t        state;
    logic [CW-1:0] cnt;   // timeout counter in SYNC, hold counter in HOLD
    logic          busy;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            busy            <= 1'b0;
            o_sync_generate <= 1'b0;
            o_link_up       <= 1'b0;
            o_tx_start      <= 1'b0;
            o_src_accept    <= 1'b0;
            o_link_err      <= 1'b0;
            o_relock_cnt    <= '0;
        end else begin
            o_link_err   <= 1'b0;
            o_tx_start   <= 1'b0;
            o_src_accept <= 1'b0;
            // A frame in flight always completes, whatever the link state does.
            if (i_tx_done) busy <= 1'b0;

            if (!i_enable) begin
                state           <= IDLE;
                o_sync_generate <= 1'b0;
                o_link_up       <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state           <= SYNC;
                        cnt             <= '0;
                        o_sync_generate <= 1'b1;
                    end
                    SYNC: begin
                        if (i_sync_complete) begin
                            state <= HOLD;
                            cnt   <= '0;
                        end else if (cnt == TO_LAST) begin
                            o_link_err <= 1'b1;
                            cnt        <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    HOLD: begin
                        if (!i_sync_complete) begin
                            state <= SYNC;
                            cnt   <= '0;
                        end else if (cnt == HOLD_LAST) begin
                            state           <= RUN;
                            o_sync_generate <= 1'b0;
                            o_link_up       <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    RUN: begin
                        if (!i_sync_complete) begin
                            state           <= SYNC;
                            cnt             <= '0;
                            o_sync_generate <= 1'b1;
                            o_link_up       <= 1'b0;
                            if (o_relock_cnt != 8'hFF) o_relock_cnt <= o_relock_cnt + 1'b1;
                        end else if (!busy && !o_tx_start) begin
                            // Only start when staying in RUN, so no start lands outside RUN.
                            o_tx_start   <= 1'b1;
                            o_src_accept <= 1'b1;
                            busy         <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign o_vl      = i_vl & {GATE_WIDTH{o_link_up}};
    assign o_cr      = i_cr & {GATE_WIDTH{o_link_up}};
    assign o_rx_pull = o_link_up & i_rx_available & i_sink_ready;

endmodule

// File: tb/tb_rxtx_link_ctrl.sv
// Directed bench for rxtx_link_ctrl: bring-up, timeout, hold length, frame pacing, gating, relock saturation.
module tb_rxtx_link_ctrl;
    localparam int GW = 4;

    logic          clk = 1'b0;
    logic          rst_n, enable, sync_complete, tx_done, rx_available, sink_ready;
    logic          sync_generate, tx_start, src_accept, rx_pull, link_up, link_err;
    logic [GW-1:0] vl_in, cr_in, vl_out, cr_out;
    logic [7:0]    relock_cnt;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;
    bit sb_on      = 1'b0;
    int exp_q[$];
    int c0, r0, s;

    rxtx_link_ctrl #(.GATE_WIDTH(GW), .HOLD_CYCLES(4), .LOCK_TIMEOUT(10)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable),
        .o_sync_generate(sync_generate), .i_sync_complete(sync_complete),
        .o_tx_start(tx_start), .i_tx_done(tx_done), .o_src_accept(src_accept),
        .i_vl(vl_in), .i_cr(cr_in), .o_vl(vl_out), .o_cr(cr_out),
        .i_rx_available(rx_available), .i_sink_ready(sink_ready), .o_rx_pull(rx_pull),
        .o_link_up(link_up), .o_link_err(link_err), .o_relock_cnt(relock_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_up(input int budget);
        for (int k = 0; k < budget && !link_up; k++) tick();
        chk("link_up_reached", link_up, 1);
    endtask

    // Scoreboard: each start must land on the cycle the bench predicted.
    always @(negedge clk) begin
        if (sb_on && (tx_start || src_accept)) begin
            chk("src_accept_vs_start", src_accept, tx_start);
            if (tx_start) begin
                chk("tx_q_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("tx_start_cycle", cyc, exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; enable = 0; sync_complete = 0; tx_done = 0;
        vl_in = '1; cr_in = '1; rx_available = 1; sink_ready = 1;
        repeat (2) tick();
        chk("rst_sync_gen", sync_generate, 0);
        chk("rst_link_up", link_up, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_src_accept", src_accept, 0);
        chk("rst_link_err", link_err, 0);
        chk("rst_relock", relock_cnt, 0);
        chk("rst_vl", vl_out, 0);
        chk("rst_rx_pull", rx_pull, 0);
        rst_n = 1; tick();

        // Lock never arrives: error every 10 cycles, link stays down.
        enable = 1; tick(); c0 = cyc;
        chk("sync_gen_after_enable", sync_generate, 1);
        for (int i = 1; i <= 25; i++) begin
            tick();
            chk("link_err_period", link_err, (i % 10 == 0));
            chk("link_up_in_sync", link_up, 0);
        end
        chk("vl_gated_sync", vl_out, 0);
        chk("cr_gated_sync", cr_out, 0);
        chk("rx_pull_gated_sync", rx_pull, 0);

        // Lock: exactly 4 HOLD cycles with sync, then RUN.
        sync_complete = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_sync_gen", sync_generate, 1);
            chk("hold_link_up", link_up, 0);
        end
        tick(); r0 = cyc;
        chk("run_sync_gen", sync_generate, 0);
        chk("run_link_up", link_up, 1);
        vl_in = 4'hA; cr_in = 4'h5; #1;
        chk("vl_pass_run", vl_out, 4'hA);
        chk("cr_pass_run", cr_out, 4'h5);

        // Frames: done returned 3 cycles after each start -> period 4.
        sb_on = 1; s = r0 + 1; exp_q.push_back(s);
        for (int k = 0; k < 4; k++) begin
            while (cyc < s + 2) tick();
            tx_done = 1; tick(); tx_done = 0;
            s += 4; exp_q.push_back(s);
        end
        while (cyc < s) tick();
        #1 chk("tx_q_drained", exp_q.size(), 0);

        // Pull follows sink_ready in RUN, drops the cycle after disable.
        for (int i = 0; i < 4; i++) begin
            sink_ready = (i % 2 == 1); #1;
            chk("rx_pull_follow", rx_pull, sink_ready);
            tick();
        end
        sink_ready = 1; enable = 0; tick();
        chk("rx_pull_after_disable", rx_pull, 0);
        chk("idle_link_up", link_up, 0);
        chk("idle_sync_gen", sync_generate, 0);

        // Done in IDLE clears busy, so a fresh start follows the next RUN entry.
        tx_done = 1; tick(); tx_done = 0;
        enable = 1; wait_up(20);
        exp_q.push_back(cyc + 1);
        tick(); tick(); #1;
        chk("start_after_idle_done", exp_q.size(), 0);

        // Async reset mid-RUN with a frame in flight.
        #2 rst_n = 0; #1;
        chk("arst_sync_gen", sync_generate, 0);
        chk("arst_link_up", link_up, 0);
        chk("arst_tx_start", tx_start, 0);
        chk("arst_src_accept", src_accept, 0);
        chk("arst_vl", vl_out, 0);
        chk("arst_cr", cr_out, 0);
        chk("arst_rx_pull", rx_pull, 0);
        sb_on = 0;
        tick(); rst_n = 1;
        tick();
        chk("rel_sync_gen", sync_generate, 1);
        chk("rel_link_up", link_up, 0);

        // 300 lock losses: count saturates at 255, gating closed each time.
        wait_up(20);
        for (int n = 1; n <= 300; n++) begin
            sync_complete = 0; tick();
            chk("relock_cnt", relock_cnt, (n < 255) ? n : 255);
            chk("relock_link_up", link_up, 0);
            chk("relock_vl", vl_out, 0);
            chk("relock_rx_pull", rx_pull, 0);
            sync_complete = 1;
            wait_up(20);
        end
        chk("relock_sat", relock_cnt, 255);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
